// File: rtl/tlc_monitor.sv
// tlc_monitor: passive checker on the one-hot traffic light bus.
// Registers the bus, decodes the phase, tracks dwell and completed
// cycles, and raises pulse/sticky flags for encoding, order and dwell
// violations. All outputs are registered from the input register.
module tlc_monitor #(
    parameter int CNT_W     = 8,
    parameter int MIN_DWELL = 1,
    parameter int MAX_DWELL = 16,
    parameter int CYC_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       lights,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic             synced,
    output logic [CNT_W-1:0] dwell,
    output logic [CYC_W-1:0] cycle_count,
    output logic             err_onehot,
    output logic             err_order,
    output logic             err_dwell,
    output logic             err_any
);

    typedef enum logic {UNSYNC = 1'b0, TRACK = 1'b1} state_t;

    localparam logic [CNT_W-1:0] DW_SAT = '1;
    localparam logic [CNT_W-1:0] DW_MAX = CNT_W'(MAX_DWELL);
    localparam logic [CNT_W-1:0] DW_MIN = CNT_W'(MIN_DWELL);
    localparam logic [CNT_W-1:0] DW_ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic [2:0]       lights_q;
    logic             q_vld;   // lights_q holds a real sample (not the reset value)
    logic [2:0]       prev;

    logic [1:0]       phase_nxt;
    logic             synced_nxt;
    logic [CNT_W-1:0] dwell_nxt;
    logic [CYC_W-1:0] cycle_nxt;
    logic             onehot_nxt, order_nxt, dwell_err_nxt, any_nxt;

    logic             legal;
    logic [1:0]       dec;
    logic [2:0]       expect_nxt;

    // Decode the registered sample and the phase expected after prev.
    always_comb begin
        legal      = 1'b0;
        dec        = 2'd0;
        unique case (lights_q)
            3'b001: begin legal = 1'b1; dec = 2'd1; end
            3'b010: begin legal = 1'b1; dec = 2'd2; end
            3'b100: begin legal = 1'b1; dec = 2'd3; end
            default: begin legal = 1'b0; dec = 2'd0; end
        endcase
        expect_nxt = {prev[1:0], prev[2]};
    end

    // Next state, next outputs and error pulses for the current sample.
    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase;
        synced_nxt    = synced;
        dwell_nxt     = dwell;
        cycle_nxt     = cycle_count;
        onehot_nxt    = 1'b0;
        order_nxt     = 1'b0;
        dwell_err_nxt = 1'b0;
        if (q_vld) begin
            if (!legal) begin
                onehot_nxt = 1'b1;
                state_nxt  = UNSYNC;
                phase_nxt  = 2'd0;
                synced_nxt = 1'b0;
                dwell_nxt  = '0;
            end else if (state == UNSYNC) begin
                // First legal sample: lock on without judging it.
                state_nxt  = TRACK;
                phase_nxt  = dec;
                synced_nxt = 1'b1;
                dwell_nxt  = DW_ONE;
            end else if (lights_q == prev) begin
                // Hold: flag only the crossing past MAX_DWELL, not each cycle after.
                if (dwell == DW_MAX)
                    dwell_err_nxt = 1'b1;
                if (dwell != DW_SAT)
                    dwell_nxt = dwell + DW_ONE;
            end else begin
                // Phase change: the outgoing phase must have been held long enough.
                if (dwell < DW_MIN)
                    dwell_err_nxt = 1'b1;
                if (lights_q == expect_nxt) begin
                    if (prev == 3'b100)
                        cycle_nxt = cycle_count + CYC_W'(1);
                end else begin
                    order_nxt = 1'b1;
                end
                phase_nxt = dec;
                dwell_nxt = DW_ONE;
            end
        end
        // Set beats clear when both land on the same cycle.
        if (onehot_nxt || order_nxt || dwell_err_nxt)
            any_nxt = 1'b1;
        else if (clr_err)
            any_nxt = 1'b0;
        else
            any_nxt = err_any;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= UNSYNC;
        else if (en)
            state <= state_nxt;
    end

    // Input register, previous sample, counters and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            lights_q    <= 3'b000;
            q_vld       <= 1'b0;
            prev        <= 3'b000;
            phase       <= 2'd0;
            synced      <= 1'b0;
            dwell       <= '0;
            cycle_count <= '0;
            err_onehot  <= 1'b0;
            err_order   <= 1'b0;
            err_dwell   <= 1'b0;
            err_any     <= 1'b0;
        end else if (en) begin
            lights_q    <= lights;
            q_vld       <= 1'b1;
            if (q_vld)
                prev <= lights_q;
            phase       <= phase_nxt;
            synced      <= synced_nxt;
            dwell       <= dwell_nxt;
            cycle_count <= cycle_nxt;
            err_onehot  <= onehot_nxt;
            err_order   <= order_nxt;
            err_dwell   <= dwell_err_nxt;
            err_any     <= any_nxt;
        end else begin
            err_onehot  <= 1'b0;
            err_order   <= 1'b0;
            err_dwell   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tlc_monitor.sv
// Bench for tlc_monitor: two instances (MIN_DWELL 1 and 3) share one
// stimulus stream; a per-cycle reference model predicts every output.
module tb_tlc_monitor;

    logic       clk = 1'b0;
    logic       rst, en, clr_err;
    logic [2:0] lights;

    logic [1:0]  phase   [2];
    logic        synced  [2];
    logic [7:0]  dwell   [2];
    logic [15:0] cyc     [2];
    logic        e_oh    [2];
    logic        e_ord   [2];
    logic        e_dw    [2];
    logic        e_any   [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tlc_monitor #(.CNT_W(8), .MIN_DWELL(1), .MAX_DWELL(16), .CYC_W(16)) u0 (
        .clk(clk), .rst(rst), .en(en), .lights(lights), .clr_err(clr_err),
        .phase(phase[0]), .synced(synced[0]), .dwell(dwell[0]), .cycle_count(cyc[0]),
        .err_onehot(e_oh[0]), .err_order(e_ord[0]), .err_dwell(e_dw[0]), .err_any(e_any[0]));

    tlc_monitor #(.CNT_W(8), .MIN_DWELL(3), .MAX_DWELL(16), .CYC_W(16)) u1 (
        .clk(clk), .rst(rst), .en(en), .lights(lights), .clr_err(clr_err),
        .phase(phase[1]), .synced(synced[1]), .dwell(dwell[1]), .cycle_count(cyc[1]),
        .err_onehot(e_oh[1]), .err_order(e_ord[1]), .err_dwell(e_dw[1]), .err_any(e_any[1]));

    // Reference model: one entry per instance.
    logic [2:0]  m_q    [2];
    logic        m_qv   [2];
    logic [2:0]  m_prev [2];
    int          m_ph   [2];   // 0 = unsynced, 1..3 = s0..s2
    int          m_dw   [2];
    logic [15:0] m_cyc  [2];
    logic        m_oh   [2];
    logic        m_ord  [2];
    logic        m_dwe  [2];
    logic        m_any  [2];

    function automatic int phase_of(input logic [2:0] v);
        if (v == 3'b001) return 1;
        if (v == 3'b010) return 2;
        if (v == 3'b100) return 3;
        return 0;
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int mn;
            int p;
            mn = (i == 0) ? 1 : 3;
            if (rst) begin
                m_q[i] = 3'b000; m_qv[i] = 1'b0; m_prev[i] = 3'b000;
                m_ph[i] = 0; m_dw[i] = 0; m_cyc[i] = '0;
                m_oh[i] = 1'b0; m_ord[i] = 1'b0; m_dwe[i] = 1'b0; m_any[i] = 1'b0;
            end else if (en) begin
                m_oh[i] = 1'b0; m_ord[i] = 1'b0; m_dwe[i] = 1'b0;
                if (m_qv[i]) begin
                    p = phase_of(m_q[i]);
                    if (p == 0) begin
                        m_oh[i] = 1'b1; m_ph[i] = 0; m_dw[i] = 0;
                    end else if (m_ph[i] == 0) begin
                        m_ph[i] = p; m_dw[i] = 1;
                    end else if (m_q[i] == m_prev[i]) begin
                        if (m_dw[i] == 16) m_dwe[i] = 1'b1;
                        if (m_dw[i] < 255) m_dw[i]++;
                    end else begin
                        if (m_dw[i] < mn) m_dwe[i] = 1'b1;
                        if (p != (m_ph[i] % 3) + 1) m_ord[i] = 1'b1;
                        else if (m_ph[i] == 3) m_cyc[i] = m_cyc[i] + 16'd1;
                        m_ph[i] = p; m_dw[i] = 1;
                    end
                    m_prev[i] = m_q[i];
                end
                if (m_oh[i] || m_ord[i] || m_dwe[i]) m_any[i] = 1'b1;
                else if (clr_err) m_any[i] = 1'b0;
                m_q[i] = lights; m_qv[i] = 1'b1;
            end else begin
                m_oh[i] = 1'b0; m_ord[i] = 1'b0; m_dwe[i] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [30:0] obs, input logic [30:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: model the edge, then compare both instances 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 2; i++) begin
            logic [30:0] obs, exp;
            obs = {phase[i], synced[i], dwell[i], cyc[i], e_oh[i], e_ord[i], e_dw[i], e_any[i]};
            exp = {m_ph[i][1:0], (m_ph[i] != 0), m_dw[i][7:0], m_cyc[i],
                   m_oh[i], m_ord[i], m_dwe[i], m_any[i]};
            chk(i == 0 ? "u0_outputs" : "u1_outputs", obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v);
        lights = v;
        step();
    endtask

    initial begin
        logic [2:0] last;
        int         pulses;
        rst = 1'b1; en = 1'b0; lights = 3'b000; clr_err = 1'b0;
        step(); step();
        chk("reset_state", {phase[0], synced[0], dwell[0], cyc[0], e_oh[0], e_ord[0], e_dw[0], e_any[0]}, '0);
        rst = 1'b0; en = 1'b1;

        // Native controller pattern: four full loops then the closing s0.
        for (int l = 0; l < 4; l++) begin
            drive(3'b001); drive(3'b010); drive(3'b100);
        end
        drive(3'b001);
        drive(3'b001);
        chk("native_cycles", 31'(cyc[0]), 31'd4);
        chk("native_no_err", 31'(e_any[0]), 31'd0);

        // Non-one-hot glitch then resync on s1.
        drive(3'b011); drive(3'b010); drive(3'b010); drive(3'b010);
        chk("onehot_sticky", 31'(e_any[0]), 31'd1);

        // Order jump s0 -> s2, then s2 -> s0 completes a cycle.
        drive(3'b001); drive(3'b100); drive(3'b001); drive(3'b001); drive(3'b001);

        // Long hold on s1: exactly one dwell pulse, dwell reaches 20.
        drive(3'b010);
        pulses = 0;
        for (int k = 0; k < 19; k++) begin
            drive(3'b010);
            pulses += int'(e_dw[0]);
        end
        drive(3'b100);
        pulses += int'(e_dw[0]);
        chk("hold_dwell", 31'(dwell[0]), 31'd20);
        chk("hold_pulses", 31'(pulses), 31'd1);

        // Short dwell (flagged by the MIN_DWELL=3 instance), then freeze.
        drive(3'b001); drive(3'b001); drive(3'b010); drive(3'b010);
        en = 1'b0;
        for (int k = 0; k < 5; k++) drive(3'($urandom));
        en = 1'b1;
        drive(3'b010); drive(3'b010);

        // Clear colliding with an order error, then clear alone.
        clr_err = 1'b1; drive(3'b010); clr_err = 1'b0;
        drive(3'b001); drive(3'b001); drive(3'b100);
        clr_err = 1'b1; drive(3'b100); clr_err = 1'b0;
        chk("clr_vs_set", 31'(e_any[0]), 31'd1);
        clr_err = 1'b1; drive(3'b100); clr_err = 1'b0;
        chk("clr_alone", 31'(e_any[0]), 31'd0);

        // Reset mid-loop.
        drive(3'b001); drive(3'b010);
        rst = 1'b1; drive(3'b100); rst = 1'b0;
        chk("mid_reset", {phase[0], synced[0], dwell[0], cyc[0], e_oh[0], e_ord[0], e_dw[0], e_any[0]}, '0);

        // Randomised traffic: mostly legal progressions and holds, some noise.
        last = 3'b001;
        for (int k = 0; k < 600; k++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0)       lights = 3'($urandom);
            else if (r < 6)   lights = last;
            else if (r < 17)  lights = {last[1:0], last[2]};
            else              lights = 3'b001 << $urandom_range(0, 2);
            if (lights == 3'b001 || lights == 3'b010 || lights == 3'b100) last = lights;
            en      = ($urandom_range(0, 9) != 0);
            clr_err = ($urandom_range(0, 9) == 0);
            rst     = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; clr_err = 1'b0; en = 1'b1;
        for (int k = 0; k < 25; k++) drive(3'b010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
